// File: rtl/sum_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter and its
// multiplexed seven-segment scanner.
package sum_bcd_pkg;

  // Conversion FSM: IDLE waits for start, SHIFT runs the double-dabble
  // iterations, DONE presents the one-cycle completion pulse.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGITS = 5;
  localparam int IN_WIDTH   = 16;

  // Segment glyphs, bit order {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to seven-segment glyph decoder with blanking.
module seg7_decoder
  import sum_bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Glyph lookup; blanked digits and non-decimal codes show nothing.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sum_bcd_converter.sv
// Sequential double-dabble converter of the accumulator total into five
// packed BCD digits, plus a free-running multiplexed display scanner.
module sum_bcd_converter
  import sum_bcd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SCAN_DIV   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [2*DATA_WIDTH-1:0]   sum,
  output logic                      busy,
  output logic                      done,
  output logic [4*BCD_DIGITS-1:0]   bcd,
  output logic [6:0]                seg,
  output logic [BCD_DIGITS-1:0]     dig_en
);

  localparam int IN_W  = 2 * DATA_WIDTH;
  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int CNT_W = $clog2(IN_W);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W = $clog2(BCD_DIGITS);

  state_t             state_reg, state_next;
  logic [IN_W-1:0]    working_reg;
  logic [BCD_W-1:0]   scratch_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [DIV_W-1:0]   div_reg;
  logic [DIG_W-1:0]   digit_reg;

  logic [BCD_W-1:0]      adj_scratch;
  logic [BCD_W+IN_W-1:0] shifted;
  logic                  last_shift;
  logic [BCD_DIGITS-1:0] blank;
  logic [3:0]            sel_digit;
  logic                  sel_blank;

  // Add-3 correction on every nibble that would overflow past 9 when doubled.
  genvar gi;
  generate
    for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
      assign adj_scratch[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5) ?
                                      scratch_reg[4*gi +: 4] + 4'd3 :
                                      scratch_reg[4*gi +: 4];
    end
  endgenerate

  assign shifted    = {adj_scratch, working_reg} << 1;
  assign last_shift = (cnt_reg == CNT_W'(IN_W - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM next-state logic; start is ignored while shifting.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: state_next = start ? SHIFT : IDLE;
      SHIFT:      state_next = last_shift ? DONE : SHIFT;
      default:    state_next = IDLE;
    endcase
  end

  // FSM outputs: busy spans the shift phase, done is the DONE state itself.
  always_comb begin
    busy = (state_reg == SHIFT);
    done = (state_reg == DONE);
  end

  // Conversion datapath: capture on start, shift while converting, publish
  // the scratch digits on the final shift so bcd only changes there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      working_reg <= '0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
      bcd_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            working_reg <= sum;
            scratch_reg <= '0;
            cnt_reg     <= '0;
          end
        end
        SHIFT: begin
          working_reg <= shifted[IN_W-1:0];
          scratch_reg <= shifted[BCD_W+IN_W-1:IN_W];
          cnt_reg     <= cnt_reg + 1'b1;
          if (last_shift) bcd_reg <= shifted[BCD_W+IN_W-1:IN_W];
        end
        default: ;
      endcase
    end
  end

  assign bcd = bcd_reg;

  // Display scanner: divider wraps every SCAN_DIV cycles and steps the digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg   <= '0;
      digit_reg <= '0;
    end else if (div_reg == DIV_W'(SCAN_DIV - 1)) begin
      div_reg   <= '0;
      digit_reg <= (digit_reg == DIG_W'(BCD_DIGITS - 1)) ? '0 : digit_reg + 1'b1;
    end else begin
      div_reg   <= div_reg + 1'b1;
    end
  end

  // A digit is blank when it and every digit above it are zero; the ones
  // digit is never blanked so a zero value still reads "0".
  generate
    for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_ones
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign blank[gi] = (bcd_reg[BCD_W-1:4*gi] == '0);
      end
      assign dig_en[gi] = (digit_reg == DIG_W'(gi));
    end
  endgenerate

  // Select the currently scanned digit and its blanking flag.
  always_comb begin
    sel_digit = '0;
    sel_blank = 1'b0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (digit_reg == DIG_W'(i)) begin
        sel_digit = bcd_reg[4*i +: 4];
        sel_blank = blank[i];
      end
    end
  end

  seg7_decoder u_dec (
    .digit (sel_digit),
    .blank (sel_blank),
    .seg   (seg)
  );

endmodule

// File: tb/tb_sum_bcd_converter.sv
// Scoreboard bench: stimulus pushes expected conversions, a monitor checks
// every cycle against an arithmetic decimal/display model.
module tb_sum_bcd_converter;

  localparam int SCAN_DIV = 4;
  localparam int LAT      = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] sum = '0;
  logic        busy, done;
  logic [19:0] bcd;
  logic [6:0]  seg;
  logic [4:0]  dig_en;

  sum_bcd_converter #(.DATA_WIDTH(8), .SCAN_DIV(SCAN_DIV)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .sum    (sum),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd),
    .seg    (seg),
    .dig_en (dig_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          done_cyc;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_done = 0;
  int   n_done = 0;
  logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: tracks the scanner and completed value, compares all outputs.
  initial begin : monitor
    int exp_val;
    int scan_div;
    int scan_dig;
    logic exp_done, exp_busy;
    int p, d;
    logic [6:0] exp_seg;
    exp_val = 0;
    scan_div = 0;
    scan_dig = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        scan_div = 0;
        scan_dig = 0;
      end else if (scan_div == SCAN_DIV - 1) begin
        scan_div = 0;
        scan_dig = (scan_dig + 1) % 5;
      end else begin
        scan_div++;
      end
      #2;
      if (reset) begin
        q.delete();
        exp_val = 0;
      end
      exp_done = 1'b0;
      if (q.size() > 0 && q[0].done_cyc == cyc) begin
        exp_done = 1'b1;
        exp_val = int'(q[0].val);
        void'(q.pop_front());
      end
      exp_busy = (q.size() > 0 && q[0].done_cyc > cyc);
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("bcd", 32'(bcd), 32'(to_bcd(exp_val)));
      chk("dig_en", 32'(dig_en), 32'(1 << scan_dig));
      p = 1;
      for (int i = 0; i < scan_dig; i++) p = p * 10;
      d = (exp_val / p) % 10;
      exp_seg = (scan_dig > 0 && exp_val < p) ? 7'h00 : glyph[d];
      chk("seg", 32'(seg), 32'(exp_seg));
      if (done) begin
        n_done++;
        $display("done cycle %0d sum=%0d bcd=%05h", cyc, exp_val, bcd);
      end
    end
  end

  // One stimulus cycle; a start is accepted only when no conversion is in flight.
  task automatic drive(input logic s, input logic [15:0] v);
    int e;
    @(negedge clk);
    reset = 1'b0;
    start = s;
    sum   = v;
    if (s) begin
      e = cyc + 1;
      if (e > last_done) begin
        q.push_back('{e + LAT, v});
        last_done = e + LAT;
        $display("start edge %0d sum=%0d accepted", e, v);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'($urandom));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    last_done = 0;
    repeat (n) @(posedge clk);
  endtask

  initial begin : stimulus
    int wait_cnt;
    repeat (3) @(posedge clk);
    // Release reset with start on the same cycle.
    drive(1'b1, 16'h0000);
    idle(22);
    drive(1'b1, 16'h03FC);
    idle(24);
    drive(1'b1, 16'hFFFF);
    drive(1'b0, 16'h0001);
    idle(20);
    drive(1'b1, 16'h0007);
    idle(4);
    drive(1'b1, 16'h1111);
    idle(16);
    drive(1'b1, 16'd1234);
    idle(7);
    do_reset(2);
    idle(22);
    // Randomized traffic including held and repeated starts.
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(3) == 0) drive(1'b1, 16'($urandom));
      else                        drive(1'b0, 16'($urandom));
    end
    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 60) begin
      idle(1);
      wait_cnt++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending %0d expected 0", q.size());
    end
    checks++;
    if (n_done < 10) begin
      errors++;
      $display("FAIL done_count: got %0d expected at least 10", n_done);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_bcd_converter.md
SUM_BCD_CONVERTER -- requirements
Module: sum_bcd_converter

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_WIDTH, 8, accumulator operand width; converted input width is 2*DATA_WIDTH = 16.
- SCAN_DIV, 4, clk cycles per display digit slot; minimum 1.
REQ-002 Ports SHALL be, one per line:
- clk  input  1  single clock, rising-edge active.
- reset  input  1  asynchronous, active-high.
- start  input  1  request conversion of sum; sampled on rising edge.
- sum  input  16  unsigned binary accumulator total from the upstream accumulator.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when bcd updates.
- bcd  output  20  five packed BCD digits; [3:0] is ones, [19:16] is ten-thousands.
- seg  output  7  active-high segments {g,f,e,d,c,b,a} for the currently scanned digit.
- dig_en  output  5  one-hot, active-high digit enable; bit i selects bcd digit i.

Function
REQ-003 FSM states SHALL be IDLE, SHIFT and DONE; only one state SHALL be active at a time.
REQ-004 IDLE or DONE with start=1 at edge E:
- capture sum into the working register.
- clear the 20-bit scratch register and the shift counter.
- go to SHIFT.
REQ-005 IDLE or DONE with start=0 SHALL go to (or stay in) IDLE.
REQ-006 SHIFT, per edge: each scratch nibble >= 5 gets +3, then {scratch, working} shifts left by 1.
REQ-007 The 16th shift edge (E+16) SHALL load bcd from the scratch result, assert done and enter DONE.
- Latency from start-sampling edge to done visible SHALL be exactly 16 cycles.
REQ-008 busy SHALL be 1 exactly while in SHIFT.
REQ-009 done SHALL be 1 exactly while in DONE, for one cycle per conversion.
REQ-010 start while in SHIFT SHALL be ignored; the conversion in flight completes unchanged.
REQ-011 sum changes after the capture edge SHALL NOT affect the result.
REQ-012 bcd SHALL hold its value between conversions and change only on the completing edge.
REQ-013 Scanner:
- A free-running divider counts 0..SCAN_DIV-1.
- On wrap, the digit index advances 0,1,2,3,4,0...
- dig_en is the one-hot decode of the digit index.
REQ-014 seg SHALL show the 0-9 glyph of the selected digit:
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
REQ-015 Leading-zero blanking:
- Digits above the most significant nonzero digit SHALL show seg=00.
- Digit 0 SHALL always be displayed, so a zero value shows "0".
REQ-016 The scanner SHALL run independently of the FSM and always display the registered bcd.

Reset
REQ-017 While reset=1, regardless of clk:
- state = IDLE; busy = 0; done = 0; bcd = 0.
- working, scratch, shift counter, divider and digit index = 0.
- dig_en = 00001; seg = 3F.
REQ-018 Reset asserted mid-conversion SHALL abort it; no done pulse SHALL follow reset release.
REQ-019 The first start after reset release SHALL be honoured on the first rising edge.

Structure
REQ-020 Package sum_bcd_pkg SHALL hold:
- the FSM state enum.
- the BCD digit count (5) and the converted input width.
- the ten segment glyph constants and the blank constant.
REQ-021 Sub-module seg7_decoder SHALL be purely combinational:
- inputs: 4-bit digit, blank flag.
- output: 7-bit seg.
REQ-022 All other logic SHALL reside in sum_bcd_converter.

Verification
REQ-023 Directed scenarios:
- Reset, sum=0000, start pulse -> busy for 16 cycles, done 1 cycle, bcd=00000, seg=3F on digit 0, digits 1-4 seg=00.
- sum=03FC, start -> done 16 cycles later, bcd=01020; scanned seg: digit0=3F, digit1=5B, digit2=3F, digit3=06, digit4=00.
- sum=FFFF, start -> bcd=65535; sum changed to 0001 one cycle after start -> result still 65535.
- sum=0007 converting; start re-pulsed at cycle 5 -> ignored, single done at cycle 16, bcd=00007.
- Reset pulse at cycle 8 of a sum=1234 conversion -> bcd=00000, busy=0, no done for 20 cycles after release.
- SCAN_DIV=4 -> dig_en rotates every 4 cycles, 00001->00010->...->10000->00001.
